// File: rtl/pwm_bank_pkg.sv
// Shared types and the PWM compare rule for the pwm_bank slice.
// Edge values narrower than PWM_W_MAX are zero-extended, which keeps unsigned compares exact.
package pwm_bank_pkg;

  localparam int PWM_W_MAX = 16;

  typedef struct packed {
    logic [PWM_W_MAX-1:0] rise;
    logic [PWM_W_MAX-1:0] fall;
  } edge_pair_t;

  // High inside [rise, fall); a fall below rise wraps the pulse across the period boundary.
  function automatic logic pwm_level(edge_pair_t e, logic [PWM_W_MAX-1:0] t);
    logic in_win;
    logic wrap;
    in_win = (e.rise <= e.fall) && (e.rise <= t) && (t < e.fall);
    wrap   = (e.fall < e.rise) && ((e.rise <= t) || (t < e.fall));
    return in_win | wrap;
  endfunction

endpackage

// File: rtl/pwm_bank_ch.sv
// One PWM channel: active edge pair, loaded only on a bank transfer, and registered output level.
module pwm_bank_ch
  import pwm_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] shadow_rise_i,
  input  logic [WIDTH-1:0] shadow_fall_i,
  input  logic [WIDTH-1:0] time_cnt_i,
  output logic             pwm_o
);

  edge_pair_t active_q, active_d;
  logic       pwm_q, pwm_d;

  always_comb begin
    active_d = active_q;
    if (load_i) begin
      active_d.rise = PWM_W_MAX'(shadow_rise_i);
      active_d.fall = PWM_W_MAX'(shadow_fall_i);
    end
    // The boundary cycle itself still uses the outgoing pair.
    pwm_d = pwm_level(active_q, PWM_W_MAX'(time_cnt_i));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// Bank of NUM_CH PWM channels with a shadow edge bank and period-aligned commit.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int  WIDTH  = 8,
  parameter int  NUM_CH = 249,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [WIDTH-1:0]  time_cnt_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [WIDTH-1:0]  wr_rise_i,
  input  logic [WIDTH-1:0]  wr_fall_i,
  input  logic              commit_i,
  output logic              commit_pending_o,
  output logic [NUM_CH-1:0] pwm_out_o
);

  logic [WIDTH-1:0] shadow_rise_q [NUM_CH];
  logic [WIDTH-1:0] shadow_fall_q [NUM_CH];
  logic [WIDTH-1:0] shadow_rise_d [NUM_CH];
  logic [WIDTH-1:0] shadow_fall_d [NUM_CH];
  logic             commit_pending_q, commit_pending_d;
  logic             boundary;
  logic             transfer;
  logic             wr_accept;

  assign boundary   = (time_cnt_i == {WIDTH{1'b1}});
  assign transfer   = boundary & (commit_i | commit_pending_q);
  assign wr_ready_o = ~commit_pending_q;
  // Out-of-range channels complete the handshake but touch nothing.
  assign wr_accept  = wr_valid_i & wr_ready_o & (32'(wr_ch_i) < 32'(NUM_CH));

  always_comb begin
    shadow_rise_d = shadow_rise_q;
    shadow_fall_d = shadow_fall_q;
    if (wr_accept) begin
      shadow_rise_d[wr_ch_i] = wr_rise_i;
      shadow_fall_d[wr_ch_i] = wr_fall_i;
    end
  end

  always_comb begin
    commit_pending_d = commit_pending_q;
    if (transfer) begin
      commit_pending_d = 1'b0;
    end else if (commit_i) begin
      commit_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_rise_q[i] <= '0;
        shadow_fall_q[i] <= '0;
      end
      commit_pending_q <= 1'b0;
    end else begin
      shadow_rise_q    <= shadow_rise_d;
      shadow_fall_q    <= shadow_fall_d;
      commit_pending_q <= commit_pending_d;
    end
  end

  assign commit_pending_o = commit_pending_q;

  // Channels see the registered shadow, so a same-cycle write waits for the next transfer.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_bank_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .load_i        (transfer),
      .shadow_rise_i (shadow_rise_q[i]),
      .shadow_fall_i (shadow_fall_q[i]),
      .time_cnt_i    (time_cnt_i),
      .pwm_o         (pwm_out_o[i])
    );
  end

endmodule
